// File: rtl/spi_minion_valrdy_responder_if.sv
// Bundle of the SPI pins and the two fabric val/rdy streams of the SPI minion responder.
interface spi_minion_valrdy_responder_if #(
  parameter int NBITS = 32
) ();
  logic             cs;
  logic             sclk;
  logic             mosi;
  logic             miso;
  logic             recv_val;
  logic             recv_rdy;
  logic [NBITS-1:0] recv_msg;
  logic             send_val;
  logic             send_rdy;
  logic [NBITS-1:0] send_msg;
  logic             overflow;
  logic             frame_err;

  modport slave (
    input  cs, sclk, mosi, recv_val, recv_msg, send_rdy,
    output miso, recv_rdy, send_val, send_msg, overflow, frame_err
  );

  modport master (
    output cs, sclk, mosi, recv_val, recv_msg, send_rdy,
    input  miso, recv_rdy, send_val, send_msg, overflow, frame_err
  );
endinterface

// File: rtl/spi_minion_valrdy_responder.sv
// SPI mode-0 minion that moves one word each way per frame, with a 2-bit
// flow-control header (W/R in, S/V out) and one-entry RX/TX buffers.
module spi_minion_valrdy_responder #(
  parameter int NBITS = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  spi_minion_valrdy_responder_if.slave    bus
);
  localparam int FLEN = NBITS + 2;
  localparam int CW   = $clog2(NBITS + 4);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic              cs_s1, cs_s2, cs_h;
  logic              sclk_s1, sclk_s2, sclk_h;
  logic              mosi_s1, mosi_s2;
  logic              tx_full, rx_full;
  logic              s_l, v_l;
  logic              miso_r, overflow_r, frame_err_r;
  logic [NBITS-1:0]  tx_data, rx_data;
  logic [FLEN-1:0]   sin;
  logic [FLEN-2:0]   sout;
  logic              cs_fall, cs_rise, sclk_rise, sclk_fall;

  assign cs_fall   = !cs_s2 && cs_h;
  assign cs_rise   = cs_s2 && !cs_h;
  assign sclk_rise = sclk_s2 && !sclk_h;
  assign sclk_fall = !sclk_s2 && sclk_h;

  // Stage 0: two-flop synchronizers plus history flops for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cs_h    <= 1'b1;
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_h  <= 1'b0;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      cs_s1   <= bus.cs;
      cs_s2   <= cs_s1;
      cs_h    <= cs_s2;
      sclk_s1 <= bus.sclk;
      sclk_s2 <= sclk_s1;
      sclk_h  <= sclk_s2;
      mosi_s1 <= bus.mosi;
      mosi_s2 <= mosi_s1;
    end
  end

  // Stage 1: frame FSM, buffer flags and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= WAIT_IDLE;
      cnt         <= '0;
      tx_full     <= 1'b0;
      rx_full     <= 1'b0;
      rx_data     <= '0;
      s_l         <= 1'b0;
      v_l         <= 1'b0;
      miso_r      <= 1'b0;
      overflow_r  <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      overflow_r  <= 1'b0;
      frame_err_r <= 1'b0;
      if (bus.recv_val && !tx_full) tx_full <= 1'b1;
      if (bus.send_rdy && rx_full)  rx_full <= 1'b0;
      case (state)
        WAIT_IDLE: begin
          // Reset preloads cs_s2 high; wait for the pin value to reach it first.
          if (cnt != CW'(3)) cnt <= cnt + CW'(1);
          else if (cs_s2)    state <= IDLE;
        end
        IDLE: begin
          if (cs_fall) begin
            s_l    <= !rx_full;
            v_l    <= tx_full;
            miso_r <= !rx_full;
            cnt    <= '0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state <= IDLE;
            if (cnt == CW'(FLEN)) begin
              if (sin[FLEN-1]) begin
                if (s_l) begin
                  rx_full <= 1'b1;
                  rx_data <= sin[NBITS-1:0];
                end else begin
                  overflow_r <= 1'b1;
                end
              end
              if (sin[FLEN-2] && v_l) tx_full <= 1'b0;
            end else begin
              frame_err_r <= 1'b1;
            end
          end else begin
            if (sclk_rise && cnt != CW'(FLEN + 1)) cnt <= cnt + CW'(1);
            if (sclk_fall) miso_r <= sout[FLEN-2];
          end
        end
        default: state <= WAIT_IDLE;
      endcase
    end
  end

  // Stage 1 data path: TX word capture and the two shift registers
  always_ff @(posedge clk) begin
    if (bus.recv_val && !tx_full) tx_data <= bus.recv_msg;
    if (state == IDLE && cs_fall) begin
      sout <= {tx_full, tx_full ? tx_data : {NBITS{1'b0}}};
    end else if (state == SHIFT && !cs_rise && sclk_fall) begin
      sout <= {sout[FLEN-3:0], 1'b0};
    end
    if (state == SHIFT && !cs_rise && sclk_rise) sin <= {sin[FLEN-2:0], mosi_s2};
  end

  assign bus.miso      = miso_r;
  assign bus.recv_rdy  = !tx_full;
  assign bus.send_val  = rx_full;
  assign bus.send_msg  = rx_data;
  assign bus.overflow  = overflow_r;
  assign bus.frame_err = frame_err_r;
endmodule
